axi_lite_sram: RTL

- AXI4-Lite memory slave that sits directly downstream of the load/store unit.
- Accepts the LSU's AR/R and AW/W/B handshakes, with word-addressed storage and byte strobes.
- Each channel has a fixed, parameterisable response latency, so pipeline stalls are exercised deterministically.
- Read and write paths are independent FSMs sharing one storage array.

---
 rtl/axi_lite_pkg.sv | 23 ++
 rtl/sram_array.sv | 31 +++
 rtl/axi_lite_sram.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite SRAM slave: response codes,
// latency counter width and the read/write FSM state encodings.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Latencies are limited to 1..15, so a 4-bit down-counter suffices.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/sram_array.sv
// DEPTH x 32 word storage split into four byte lanes. One synchronous
// byte-strobed write port and one combinational read port. Contents have
// no reset so they survive a bus reset. A read of the word being written
// in the same cycle returns the pre-write contents.
module sram_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        // Byte lane write: only lanes whose strobe bit is set are updated.
        always_ff @(posedge clk) begin
            if (we && wstrb[gi]) begin
                lane_mem[widx] <= wdata[8*gi +: 8];
            end
        end

        assign rdata[8*gi +: 8] = lane_mem[ridx];
    end

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite memory slave with fixed per-channel response latency.
// Independent read and write FSMs share one sram_array; one outstanding
// transaction per channel. Addresses outside [BASE, BASE+DEPTH*4) answer
// SLVERR and never touch storage.
module axi_lite_sram
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DEPTH  = 1024,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000),
    parameter int                RD_LAT = 2,
    parameter int                WR_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

    // Address decode: offsets below BASE wrap to large values and fall out
    // of range naturally. addr[1:0] never reaches the word index.
    logic [ADDR_W-1:0] ar_off;
    logic [ADDR_W-1:0] aw_off;
    logic              ar_in_range;
    logic              aw_in_range;
    logic [IDX_W-1:0]  ar_idx;
    logic [IDX_W-1:0]  aw_idx;

    assign ar_off      = araddr - BASE;
    assign aw_off      = awaddr - BASE;
    assign ar_in_range = ar_off < SPAN;
    assign aw_in_range = aw_off < SPAN;
    assign ar_idx      = ar_off[IDX_W+1:2];
    assign aw_idx      = aw_off[IDX_W+1:2];

    // Read channel state
    rd_state_e         rd_state_reg, rd_state_next;
    logic [CNT_W-1:0]  rd_cnt_reg, rd_cnt_next;
    logic [IDX_W-1:0]  rd_idx_reg, rd_idx_next;
    logic              rd_ok_reg, rd_ok_next;
    logic [31:0]       rdata_reg, rdata_next;
    logic [1:0]        rresp_reg, rresp_next;

    // Write channel state
    wr_state_e         wr_state_reg, wr_state_next;
    logic [CNT_W-1:0]  wr_cnt_reg, wr_cnt_next;
    logic              have_aw_reg, have_aw_next;
    logic              have_w_reg, have_w_next;
    logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
    logic              wr_ok_reg, wr_ok_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [3:0]        wstrb_reg, wstrb_next;
    logic [1:0]        bresp_reg, bresp_next;

    logic              mem_we;
    logic [31:0]       mem_rdata;

    // The commit is masked during reset so a write whose latency expires on
    // the reset edge is dropped along with the rest of the transaction.
    assign mem_we = !rst && (wr_state_reg == W_WAIT) && (wr_cnt_reg == '0) && wr_ok_reg;

    sram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .widx  (wr_idx_reg),
        .wdata (wdata_reg),
        .wstrb (wstrb_reg),
        .ridx  (rd_idx_reg),
        .rdata (mem_rdata)
    );

    assign arready = (rd_state_reg == R_IDLE);
    assign rvalid  = (rd_state_reg == R_RESP);
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;

    assign awready = (wr_state_reg == W_IDLE) && !have_aw_reg;
    assign wready  = (wr_state_reg == W_IDLE) && !have_w_reg;
    assign bvalid  = (wr_state_reg == W_RESP);
    assign bresp   = bresp_reg;

    // Read FSM next-state: accept AR, count down the latency, then present data.
    always_comb begin
        rd_state_next = rd_state_reg;
        rd_cnt_next   = rd_cnt_reg;
        rd_idx_next   = rd_idx_reg;
        rd_ok_next    = rd_ok_reg;
        rdata_next    = rdata_reg;
        rresp_next    = rresp_reg;
        case (rd_state_reg)
            R_IDLE: begin
                if (arvalid) begin
                    rd_idx_next   = ar_idx;
                    rd_ok_next    = ar_in_range;
                    rd_cnt_next   = CNT_W'(RD_LAT - 1);
                    rd_state_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_reg == '0) begin
                    rdata_next    = rd_ok_reg ? mem_rdata : 32'h0;
                    rresp_next    = rd_ok_reg ? RESP_OKAY : RESP_SLVERR;
                    rd_state_next = R_RESP;
                end else begin
                    rd_cnt_next = rd_cnt_reg - 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Write FSM next-state: collect AW and W in any order, count down, commit, respond.
    always_comb begin
        wr_state_next = wr_state_reg;
        wr_cnt_next   = wr_cnt_reg;
        have_aw_next  = have_aw_reg;
        have_w_next   = have_w_reg;
        wr_idx_next   = wr_idx_reg;
        wr_ok_next    = wr_ok_reg;
        wdata_next    = wdata_reg;
        wstrb_next    = wstrb_reg;
        bresp_next    = bresp_reg;
        case (wr_state_reg)
            W_IDLE: begin
                if (awvalid && !have_aw_reg) begin
                    have_aw_next = 1'b1;
                    wr_idx_next  = aw_idx;
                    wr_ok_next   = aw_in_range;
                end
                if (wvalid && !have_w_reg) begin
                    have_w_next = 1'b1;
                    wdata_next  = wdata;
                    wstrb_next  = wstrb;
                end
                // Start the latency count on the edge that completes the pair.
                if (have_aw_next && have_w_next) begin
                    wr_cnt_next   = CNT_W'(WR_LAT - 1);
                    wr_state_next = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_cnt_reg == '0) begin
                    bresp_next    = wr_ok_reg ? RESP_OKAY : RESP_SLVERR;
                    wr_state_next = W_RESP;
                end else begin
                    wr_cnt_next = wr_cnt_reg - 1'b1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    have_aw_next  = 1'b0;
                    have_w_next   = 1'b0;
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    // State registers for both channels; reset drops any pending transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_reg <= R_IDLE;
            rd_cnt_reg   <= '0;
            rd_idx_reg   <= '0;
            rd_ok_reg    <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
            wr_state_reg <= W_IDLE;
            wr_cnt_reg   <= '0;
            have_aw_reg  <= 1'b0;
            have_w_reg   <= 1'b0;
            wr_idx_reg   <= '0;
            wr_ok_reg    <= 1'b0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            rd_state_reg <= rd_state_next;
            rd_cnt_reg   <= rd_cnt_next;
            rd_idx_reg   <= rd_idx_next;
            rd_ok_reg    <= rd_ok_next;
            rdata_reg    <= rdata_next;
            rresp_reg    <= rresp_next;
            wr_state_reg <= wr_state_next;
            wr_cnt_reg   <= wr_cnt_next;
            have_aw_reg  <= have_aw_next;
            have_w_reg   <= have_w_next;
            wr_idx_reg   <= wr_idx_next;
            wr_ok_reg    <= wr_ok_next;
            wdata_reg    <= wdata_next;
            wstrb_reg    <= wstrb_next;
            bresp_reg    <= bresp_next;
        end
    end

endmodule
